cmd_receiver: RTL and testbench
===============================

Name: cmd_receiver

Overview:
Downstream stage on the far end of the UART link from the command master. Consumes the byte stream from a UART receiver (rdy/rx_data/clr_rdy handshake) and reassembles 16-bit commands sent high byte first, then low byte. Presents the command with a sticky ready flag to the command decoder. Recovers from dropped bytes with an inter-byte timeout.

Parameters:
TIMEOUT_CYC, 16'd50000, max cycles allowed between high and low byte before the frame is discarded
TMR_W, 16, width of timeout counter; must hold TIMEOUT_CYC

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
rx_rdy  input  1  UART receiver has an unread byte
rx_data  input  8  received byte, valid while rx_rdy=1
clr_rx_rdy  output  1  combinational; high in the cycle a byte is consumed
clr_cmd_rdy  input  1  consumer acknowledges cmd
cmd  output  16  last completed command
cmd_rdy  output  1  sticky; a completed command is waiting
cmd_ovr  output  1  sticky; a command completed while cmd_rdy was still set
frm_err  output  1  one-cycle pulse: timeout or (option) checksum fail

Behaviour:
- Reset (rst=1 at a clk edge): state=WAIT_HI, cmd=0, cmd_rdy=0, cmd_ovr=0, frm_err=0, hi_byte=0, timer=0. Reset mid-frame discards the partial frame.
- Byte acceptance: in WAIT_HI/WAIT_LO (and WAIT_CK with option), rx_rdy=1 -> clr_rx_rdy=1 same cycle, byte captured at that edge. In no other case is clr_rx_rdy asserted.
- WAIT_HI: on accept, hi_byte<=rx_data, timer<=0, -> WAIT_LO.
- WAIT_LO: timer increments each cycle rx_rdy=0. If timer==TIMEOUT_CYC-1 and rx_rdy=0 -> frm_err pulse next cycle, -> WAIT_HI. A byte arriving in that same cycle wins: it is accepted, no timeout. On accept: cmd<={hi_byte,rx_data}, cmd_rdy<=1, -> WAIT_HI.
- Latency: cmd and cmd_rdy valid the cycle after the low byte is accepted.
- cmd_rdy cleared by clr_cmd_rdy; if completion and clr_cmd_rdy coincide, set wins (cmd_rdy stays 1).
- Overrun: completion while cmd_rdy=1 and clr_cmd_rdy=0 -> cmd overwritten, cmd_ovr<=1. cmd_ovr clears only on clr_cmd_rdy (when no simultaneous overrun).
- Timer saturates; it never wraps.
- rx_data ignored whenever rx_rdy=0.

Optional Feature:
CMD_CHKSUM_EN defined: third byte follows low byte; extra state WAIT_CK with the same timeout rule. Expected value = ~(hi_byte+lo_byte) mod 256. Match -> cmd/cmd_rdy update as above. Mismatch -> frm_err pulse, cmd/cmd_rdy unchanged, -> WAIT_HI. Undefined: two-byte frames; WAIT_CK is absent; frm_err is driven only by timeout.

Decomposition:
- Shared package cmd_pkg: state_t enum {WAIT_HI, WAIT_LO, WAIT_CK}, CMD_W=16, default TIMEOUT_CYC constant, checksum function.
- Optional sub-module byte_timeout_tmr: clear, enable, parameterised terminal count, done output. Everything else stays in one module.

Test Plan:
- rx bytes 0xA5 then 0x3C, 10 cycles apart -> clr_rx_rdy pulses twice, cmd=0xA53C with cmd_rdy=1 the cycle after the 2nd accept; clr_cmd_rdy -> cmd_rdy=0.
- High byte 0x12, then silence for TIMEOUT_CYC cycles (TIMEOUT_CYC=20 in bench) -> frm_err single pulse, cmd unchanged; next 0x34,0x56 -> cmd=0x3456.
- Low byte arrives exactly on the terminal-count cycle -> accepted, no frm_err.
- Two frames 0x0102 then 0x0304 without clr_cmd_rdy -> cmd=0x0304, cmd_ovr=1; clr_cmd_rdy coincident with a 3rd completion -> cmd_rdy stays 1.
- rst asserted after high byte 0xFF -> next frame 0x11,0x22 yields cmd=0x1122, not 0xFF11.
- CMD_CHKSUM_EN: 0x10,0x20,0xCF -> cmd=0x1020; 0x10,0x20,0x00 -> frm_err pulse, cmd_rdy stays 0.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types and constants for the command receiver: FSM states, command width,
// default inter-byte timeout and the frame checksum rule.
package cmd_pkg;

  localparam int unsigned CMD_W           = 16;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_CK = 2'd2
  } state_t;

  // Checksum byte a sender appends to a frame: bitwise inverse of the 8-bit byte sum.
  function automatic logic [7:0] chksum(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] sum;
    sum = hi + lo;
    return ~sum;
  endfunction

endpackage

// File: rtl/byte_timeout_tmr.sv
// Saturating inter-byte timer: counts enabled cycles since the last clear and flags
// the cycle in which the count sits on the terminal value.
module byte_timeout_tmr #(
  parameter int unsigned      TMR_W    = 16,
  parameter logic [TMR_W-1:0] TERM_CNT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == TERM_CNT);

endmodule

// File: rtl/cmd_receiver.sv
// cmd_receiver: rebuilds 16-bit commands (high byte, then low byte) from a UART byte stream.
// Define CMD_CHKSUM_EN to require a third byte ~(hi+lo) per frame, checked before delivery.
module cmd_receiver
  import cmd_pkg::*;
#(
  parameter int unsigned      TMR_W       = 16,
  parameter logic [TMR_W-1:0] TIMEOUT_CYC = TMR_W'(TIMEOUT_CYC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             clr_rx_rdy,
  input  logic             clr_cmd_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  output logic             cmd_ovr,
  output logic             frm_err
);

  state_t             state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               cmd_ovr_q, cmd_ovr_d;
  logic               frm_err_q, frm_err_d;
  logic               accept, complete, tmr_done;
`ifdef CMD_CHKSUM_EN
  logic [7:0]         lo_q, lo_d;
`endif

`ifdef CMD_CHKSUM_EN
  assign accept = rx_rdy && (state_q == WAIT_HI || state_q == WAIT_LO || state_q == WAIT_CK);
`else
  assign accept = rx_rdy && (state_q == WAIT_HI || state_q == WAIT_LO);
`endif
  assign clr_rx_rdy = accept;

  // Counts idle cycles since the last accepted byte; only meaningful mid-frame.
  byte_timeout_tmr #(
    .TMR_W   (TMR_W),
    .TERM_CNT(TIMEOUT_CYC - TMR_W'(1))
  ) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(!rx_rdy && (state_q != WAIT_HI)),
    .done  (tmr_done)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    frm_err_d = 1'b0;
    complete  = 1'b0;
`ifdef CMD_CHKSUM_EN
    lo_d      = lo_q;
`endif
    case (state_q)
      WAIT_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (accept) begin
`ifdef CMD_CHKSUM_EN
          lo_d     = rx_data;
          state_d  = WAIT_CK;
`else
          cmd_d    = {hi_q, rx_data};
          complete = 1'b1;
          state_d  = WAIT_HI;
`endif
        end else if (tmr_done) begin
          frm_err_d = 1'b1;
          state_d   = WAIT_HI;
        end
      end
`ifdef CMD_CHKSUM_EN
      WAIT_CK: begin
        if (accept) begin
          if (rx_data == chksum(hi_q, lo_q)) begin
            cmd_d    = {hi_q, lo_q};
            complete = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
          state_d = WAIT_HI;
        end else if (tmr_done) begin
          frm_err_d = 1'b1;
          state_d   = WAIT_HI;
        end
      end
`endif
      default: state_d = WAIT_HI;
    endcase

    // A completion always wins over an acknowledge arriving in the same cycle.
    cmd_rdy_d = complete || (cmd_rdy_q && !clr_cmd_rdy);
    if (complete && cmd_rdy_q && !clr_cmd_rdy) begin
      cmd_ovr_d = 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_ovr_d = 1'b0;
    end else begin
      cmd_ovr_d = cmd_ovr_q;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      cmd_ovr_q <= 1'b0;
      frm_err_q <= 1'b0;
`ifdef CMD_CHKSUM_EN
      lo_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      cmd_ovr_q <= cmd_ovr_d;
      frm_err_q <= frm_err_d;
`ifdef CMD_CHKSUM_EN
      lo_q      <= lo_d;
`endif
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign cmd_ovr = cmd_ovr_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_cmd_receiver.sv
// Bench for cmd_receiver: directed frames plus random byte traffic, checked every cycle
// against a frame-level reference model through a scoreboard queue.
module tb_cmd_receiver;

  localparam int T = 20;
`ifdef CMD_CHKSUM_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  typedef struct {
    int unsigned cyc;
    logic        clr;
    logic [15:0] cmd;
    logic        rdy;
    logic        ovr;
    logic        err;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy, cmd_ovr, frm_err;

  always #5 clk = ~clk;

  cmd_receiver #(
    .TMR_W      (16),
    .TIMEOUT_CYC(16'(T))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .cmd_ovr    (cmd_ovr),
    .frm_err    (frm_err)
  );

  // Reference model: bytes of the frame collected so far and idle cycles since the last one.
  logic [7:0]  frame_q[$];
  int          idle = 0;
  logic [15:0] m_cmd = 16'h0;
  logic        m_rdy = 1'b0, m_ovr = 1'b0, m_err = 1'b0;
  bit          known = 1'b0;
  int unsigned cyc = 0;

  snap_t       sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic void model_step(input logic r, input logic rdy, input logic [7:0] d,
                                     input logic clr);
    logic        done = 1'b0;
    logic        err = 1'b0;
    logic [15:0] new_cmd = 16'h0;
    logic [7:0]  sum;
    if (r) begin
      frame_q.delete();
      idle  = 0;
      m_cmd = 16'h0;
      m_rdy = 1'b0;
      m_ovr = 1'b0;
      m_err = 1'b0;
      known = 1'b1;
      return;
    end
    if (rdy) begin
      frame_q.push_back(d);
      idle = 0;
      if (frame_q.size() == FRAME_LEN) begin
        sum = frame_q[0] + frame_q[1];
        if (FRAME_LEN == 3 && frame_q[FRAME_LEN-1] != ~sum) begin
          err = 1'b1;
        end else begin
          done    = 1'b1;
          new_cmd = {frame_q[0], frame_q[1]};
        end
        frame_q.delete();
      end
    end else if (frame_q.size() > 0) begin
      idle++;
      if (idle == T) begin
        err = 1'b1;
        frame_q.delete();
      end
    end
    if (done && m_rdy && !clr) m_ovr = 1'b1;
    else if (clr)              m_ovr = 1'b0;
    if (done) begin
      m_cmd = new_cmd;
      m_rdy = 1'b1;
    end else if (clr) begin
      m_rdy = 1'b0;
    end
    m_err = err;
  endfunction

  // One clock cycle of stimulus; the expectation for this cycle is queued before the model advances.
  task automatic drive(input logic r, input logic rdy, input logic [7:0] d, input logic clr);
    snap_t s;
    @(posedge clk);
    #1;
    cyc++;
    rst         = r;
    rx_rdy      = rdy;
    rx_data     = rdy ? d : 8'($urandom);
    clr_cmd_rdy = clr;
    if (known) begin
      s.cyc = cyc;
      s.clr = rdy;
      s.cmd = m_cmd;
      s.rdy = m_rdy;
      s.ovr = m_ovr;
      s.err = m_err;
      sb.push_back(s);
    end
    model_step(r, rdy, d, clr);
  endtask

  task automatic send(input logic [7:0] d, input logic clr = 1'b0);
    drive(1'b0, 1'b1, d, clr);
  endtask

  task automatic idle_cycles(input int n, input bit rand_clr = 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 8'h00, rand_clr ? ($urandom_range(0, 5) == 0) : 1'b0);
    end
  endtask

  task automatic ack();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        s = sb.pop_front();
        vectors++;
        if (clr_rx_rdy !== s.clr || cmd !== s.cmd || cmd_rdy !== s.rdy ||
            cmd_ovr !== s.ovr || frm_err !== s.err) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: got clr_rx_rdy=%b cmd=%h cmd_rdy=%b cmd_ovr=%b frm_err=%b, expected clr_rx_rdy=%b cmd=%h cmd_rdy=%b cmd_ovr=%b frm_err=%b",
                   s.cyc, clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, frm_err,
                   s.clr, s.cmd, s.rdy, s.ovr, s.err);
        end
      end
    end
  end

  initial begin : stimulus
    int gap;
    int sel;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    idle_cycles(2);

    // Basic frame with a 10-cycle spacing, then acknowledge.
    send(8'hA5);
    idle_cycles(9);
    send(8'h3C);
    idle_cycles(2);
    ack();
    idle_cycles(2);

    // High byte then silence: timeout, then a clean frame.
    send(8'h12);
    idle_cycles(T + 3);
    send(8'h34);
    idle_cycles(1);
    send(8'h56);
    idle_cycles(2);
    ack();

    // Low byte on the terminal-count cycle wins; one cycle later loses.
    send(8'h77);
    idle_cycles(T - 1);
    send(8'h88);
    idle_cycles(1);
    ack();
    send(8'h99);
    idle_cycles(T);
    send(8'hAA);
    idle_cycles(T + 1);

    // Overrun, then acknowledge coincident with a third completion.
    send(8'h01);
    send(8'h02);
    idle_cycles(1);
    send(8'h03);
    send(8'h04);
    idle_cycles(1);
    send(8'h05);
    send(8'h06, 1'b1);
    idle_cycles(1);
    ack();
    idle_cycles(1);

    // Reset mid-frame discards the pending high byte.
    send(8'hFF);
    idle_cycles(1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h11);
    send(8'h22);
    idle_cycles(2);
    ack();

`ifdef CMD_CHKSUM_EN
    send(8'h10);
    send(8'h20);
    send(8'hCF);
    idle_cycles(2);
    ack();
    send(8'h10);
    send(8'h20);
    send(8'h00);
    idle_cycles(2);
`endif

    // Random traffic: mostly short gaps, with gaps around the timeout boundary mixed in.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       gap = $urandom_range(0, 4);
      else if (sel == 7) gap = T - 1;
      else if (sel == 8) gap = T;
      else               gap = $urandom_range(T + 1, T + 5);
      idle_cycles(gap, 1'b1);
      send(8'($urandom), $urandom_range(0, 5) == 0);
    end

    idle_cycles(3);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
